ws2812_rx: RTL and testbench

Receive-side decoder for the WS2812 single-wire LED protocol, running on the same 200 MHz `clk_in` domain as the transmit controller. It sits on an input pin fed from a WS2812 chain (or the transmit path looped back) and measures high-pulse widths to recover data bits. It assembles 24-bit pixel words MSB first, emits each with an index, and detects the reset code (long low) that ends a frame.

---
 rtl/ws2812_rx.sv | 203 ++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receive decoder.
// Measures high-pulse widths on a synchronized din_in to recover bits,
// assembles 24-bit pixels MSB first with a per-frame index, and detects
// the long-low reset code that terminates a frame.
//
// Ports:
//   clk_in          clock (200 MHz)
//   rst_n_in        asynchronous active-low reset
//   din_in          asynchronous serial WS2812 data input
//   pixel_rdy_out   one-cycle strobe, pixel_data_out/pixel_idx_out valid
//   pixel_data_out  received pixel, first-received bit in [23]
//   pixel_idx_out   0-based pixel index within the current frame
//   frame_done_out  one-cycle strobe at reset code after at least one bit
//   err_out         one-cycle strobe on glitch, over-long high, or partial pixel
module ws2812_rx #(
    parameter int unsigned CNT_T_MIN = 20,
    parameter int unsigned CNT_T_TH  = 120,
    parameter int unsigned CNT_T_MAX = 400,
    parameter int unsigned CNT_RST   = 10000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        din_in,
    output logic        pixel_rdy_out,
    output logic [23:0] pixel_data_out,
    output logic [7:0]  pixel_idx_out,
    output logic        frame_done_out,
    output logic        err_out
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 5;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned IDX_W = 8;

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] T_MIN    = CNT_W'(CNT_T_MIN);
    localparam logic [CNT_W-1:0] T_TH     = CNT_W'(CNT_T_TH);
    localparam logic [CNT_W-1:0] T_MAX    = CNT_W'(CNT_T_MAX);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(CNT_RST - 1);
    localparam logic [CNT_W-1:0] RST_VAL  = CNT_W'(CNT_RST);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIX_W - 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              s1, s2;
    logic [CNT_W-1:0]  hi_cnt, hi_cnt_nxt;
    logic [CNT_W-1:0]  lo_cnt, lo_cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [PIX_W-1:0]  shift_reg, shift_reg_nxt;
    logic [IDX_W-1:0]  pix_idx, pix_idx_nxt;
    logic              bit_seen, bit_seen_nxt;
    logic              pixel_rdy_nxt;
    logic [PIX_W-1:0]  pixel_data_nxt;
    logic [IDX_W-1:0]  pixel_idx_nxt;
    logic              frame_done_nxt;
    logic              err_nxt;

    logic [CNT_W-1:0]  hi_inc, lo_inc;
    logic              bit_val;

    // Two-flop synchronizer for the asynchronous data pin
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din_in;
            s2 <= s1;
        end
    end

    // Saturating increments
    assign hi_inc  = (hi_cnt == CNT_SAT) ? hi_cnt : hi_cnt + CNT_W'(1);
    assign lo_inc  = (lo_cnt == CNT_SAT) ? lo_cnt : lo_cnt + CNT_W'(1);
    assign bit_val = (hi_cnt >= T_TH);

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= SYNC;
            hi_cnt         <= '0;
            lo_cnt         <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            pix_idx        <= '0;
            bit_seen       <= 1'b0;
            pixel_rdy_out  <= 1'b0;
            pixel_data_out <= '0;
            pixel_idx_out  <= '0;
            frame_done_out <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            state          <= state_nxt;
            hi_cnt         <= hi_cnt_nxt;
            lo_cnt         <= lo_cnt_nxt;
            bit_cnt        <= bit_cnt_nxt;
            shift_reg      <= shift_reg_nxt;
            pix_idx        <= pix_idx_nxt;
            bit_seen       <= bit_seen_nxt;
            pixel_rdy_out  <= pixel_rdy_nxt;
            pixel_data_out <= pixel_data_nxt;
            pixel_idx_out  <= pixel_idx_nxt;
            frame_done_out <= frame_done_nxt;
            err_out        <= err_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt      = state;
        hi_cnt_nxt     = hi_cnt;
        lo_cnt_nxt     = lo_cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_reg_nxt  = shift_reg;
        pix_idx_nxt    = pix_idx;
        bit_seen_nxt   = bit_seen;
        pixel_rdy_nxt  = 1'b0;
        pixel_data_nxt = pixel_data_out;
        pixel_idx_nxt  = pixel_idx_out;
        frame_done_nxt = 1'b0;
        err_nxt        = 1'b0;

        unique case (state)
            // Disarmed: wait for a full reset code before decoding
            SYNC: begin
                if (s2) begin
                    lo_cnt_nxt = '0;
                end else if (lo_cnt == RST_LAST) begin
                    // Load past the reset test so LOW does not report a frame end
                    state_nxt    = LOW;
                    lo_cnt_nxt   = RST_VAL;
                    bit_cnt_nxt  = '0;
                    pix_idx_nxt  = '0;
                    bit_seen_nxt = 1'b0;
                end else begin
                    lo_cnt_nxt = lo_inc;
                end
            end

            LOW: begin
                if (s2) begin
                    state_nxt  = HIGH;
                    hi_cnt_nxt = CNT_W'(1);
                    lo_cnt_nxt = '0;
                end else begin
                    lo_cnt_nxt = lo_inc;
                    // Equality test fires once per low interval
                    if (lo_cnt == RST_LAST) begin
                        frame_done_nxt = bit_seen;
                        err_nxt        = (bit_cnt != '0);
                        bit_cnt_nxt    = '0;
                        pix_idx_nxt    = '0;
                        bit_seen_nxt   = 1'b0;
                    end
                end
            end

            HIGH: begin
                if (s2) begin
                    hi_cnt_nxt = hi_inc;
                    // Stuck-high line: abandon the frame and resynchronize
                    if (hi_inc >= T_MAX) begin
                        state_nxt    = SYNC;
                        lo_cnt_nxt   = '0;
                        err_nxt      = 1'b1;
                        bit_cnt_nxt  = '0;
                        pix_idx_nxt  = '0;
                        bit_seen_nxt = 1'b0;
                    end
                end else begin
                    state_nxt  = LOW;
                    lo_cnt_nxt = CNT_W'(1);
                    if (hi_cnt < T_MIN) begin
                        err_nxt = 1'b1;
                    end else begin
                        shift_reg_nxt = {shift_reg[PIX_W-2:0], bit_val};
                        bit_seen_nxt  = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt_nxt    = '0;
                            pixel_rdy_nxt  = 1'b1;
                            pixel_data_nxt = {shift_reg[PIX_W-2:0], bit_val};
                            pixel_idx_nxt  = pix_idx;
                            pix_idx_nxt    = pix_idx + IDX_W'(1);
                        end else begin
                            bit_cnt_nxt = bit_cnt + BIT_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus pushes expected strobes into a
// queue, a negedge monitor pops and compares on every output strobe.
module tb_ws2812_rx;

    localparam int unsigned RST_CNT = 2000;
    localparam int unsigned RST_LOW = RST_CNT + 50;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        pixel_rdy;
    logic [23:0] pixel_data;
    logic [7:0]  pixel_idx;
    logic        frame_done;
    logic        err;

    typedef struct {
        bit          pix;
        bit          done;
        bit          er;
        logic [23:0] data;
        logic [7:0]  idx;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  t0h, t0l, t1h, t1l;

    ws2812_rx #(
        .CNT_T_MIN(20),
        .CNT_T_TH (120),
        .CNT_T_MAX(400),
        .CNT_RST  (RST_CNT)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .din_in        (din),
        .pixel_rdy_out (pixel_rdy),
        .pixel_data_out(pixel_data),
        .pixel_idx_out (pixel_idx),
        .frame_done_out(frame_done),
        .err_out       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every strobe cycle must match the head of the expectation queue
    always @(negedge clk) begin
        if (rst_n && (pixel_rdy || frame_done || err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event pix=%0b done=%0b err=%0b data=%h idx=%0d, required no event",
                         pixel_rdy, frame_done, err, pixel_data, pixel_idx);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ({pixel_rdy, frame_done, err} != {e.pix, e.done, e.er} ||
                    (e.pix && (pixel_data != e.data || pixel_idx != e.idx))) begin
                    errors++;
                    $display("FAIL event got pix=%0b done=%0b err=%0b data=%h idx=%0d, required pix=%0b done=%0b err=%0b data=%h idx=%0d",
                             pixel_rdy, frame_done, err, pixel_data, pixel_idx,
                             e.pix, e.done, e.er, e.data, e.idx);
                end
            end
        end
    end

    task automatic push_ev(input bit p, input bit d, input bit e,
                           input logic [23:0] data, input logic [7:0] idx);
        ev_t ev;
        ev.pix  = p;
        ev.done = d;
        ev.er   = e;
        ev.data = data;
        ev.idx  = idx;
        exp_q.push_back(ev);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rdy"},  32'(pixel_rdy),  32'd0);
        check({tag, "_data"}, 32'(pixel_data), 32'd0);
        check({tag, "_idx"},  32'(pixel_idx),  32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
        check({tag, "_err"},  32'(err),        32'd0);
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    // Send nbits MSB first; expect a pixel strobe at the 24th falling edge when push set.
    // glitch_after >= 0 inserts a 15-clock high after that bit index.
    task automatic send_bits(input logic [23:0] d, input int nbits, input bit push,
                             input logic [7:0] idx, input int glitch_after);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = d[23-i];
            hold(1'b1, b ? t1h : t0h);
            if (push && nbits == 24 && i == 23) push_ev(1'b1, 1'b0, 1'b0, d, idx);
            hold(1'b0, b ? t1l : t0l);
            if (i == glitch_after) begin
                hold(1'b1, 15);
                push_ev(1'b0, 1'b0, 1'b1, 24'h0, 8'h0);
                hold(1'b0, t0l);
            end
        end
    endtask

    task automatic frame_end(input bit d, input bit e);
        if (d || e) push_ev(1'b0, d, e, 24'h0, 8'h0);
        hold(1'b0, RST_LOW);
    endtask

    task automatic set_timing(input int a, input int b, input int c, input int e);
        t0h = a; t0l = b; t1h = c; t1l = e;
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        set_timing(40, 20, 130, 20);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Single pixel, nominal timing, arm with a reset code first
        hold(1'b0, RST_LOW);
        set_timing(80, 170, 160, 90);
        send_bits(24'hA53C0F, 24, 1'b1, 8'd0, -1);
        frame_end(1'b1, 1'b0);

        // Three pixels back-to-back
        set_timing(40, 20, 130, 20);
        send_bits(24'hFF0000, 24, 1'b1, 8'd0, -1);
        send_bits(24'h00FF00, 24, 1'b1, 8'd1, -1);
        send_bits(24'h0000FF, 24, 1'b1, 8'd2, -1);
        frame_end(1'b1, 1'b0);

        // Glitch between bits 5 and 6 is flagged but does not corrupt the pixel
        send_bits(24'h123456, 24, 1'b1, 8'd0, 5);
        frame_end(1'b1, 1'b0);

        // Threshold boundary: 119 decodes 0, 120 decodes 1
        set_timing(119, 90, 120, 90);
        send_bits(24'h5A5A5A, 24, 1'b1, 8'd0, -1);
        frame_end(1'b1, 1'b0);

        // Partial pixel at frame end: done and err together, next frame at index 0
        set_timing(40, 20, 130, 20);
        send_bits(24'hABCDEF, 12, 1'b0, 8'd0, -1);
        frame_end(1'b1, 1'b1);
        send_bits(24'h654321, 24, 1'b1, 8'd0, -1);
        frame_end(1'b1, 1'b0);

        // Stuck-high fault mid-frame: err once, disarmed until a reset code
        send_bits(24'h0F0F0F, 8, 1'b0, 8'd0, -1);
        push_ev(1'b0, 1'b0, 1'b1, 24'h0, 8'h0);
        hold(1'b1, 500);
        send_bits(24'h111111, 24, 1'b0, 8'd0, -1);
        hold(1'b0, 100);
        hold(1'b0, RST_LOW);
        send_bits(24'h222222, 24, 1'b1, 8'd0, -1);
        frame_end(1'b1, 1'b0);
        check("data_hold", 32'(pixel_data), 32'h00222222);
        check("idx_hold",  32'(pixel_idx),  32'h0);

        // Reset mid-pixel clears outputs asynchronously and disarms decoding
        send_bits(24'h333333, 10, 1'b0, 8'd0, -1);
        din   = 1'b0;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        check_outputs_zero("midreset_hold");
        rst_n = 1'b1;
        send_bits(24'h444444, 24, 1'b0, 8'd0, -1);
        hold(1'b0, 100);
        hold(1'b0, RST_LOW);
        send_bits(24'h555555, 24, 1'b1, 8'd0, -1);
        frame_end(1'b1, 1'b0);

        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
